sequence_generator_moore: RTL and testbench

//   Serial pattern transmitter, the counterpart of the lab's serial sequence detector.

---
 rtl/seq_gen_pkg.sv | 20 ++
 rtl/pattern_shifter.sv | 40 ++++
 rtl/sequence_generator_moore.sv | 142 ++++++++++++++
 tb/tb_sequence_generator_moore.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) res = res + 1;
      return res;
   endfunction

endpackage

// File: rtl/pattern_shifter.sv
// Pattern register rotated MSB-first plus bit index; rotation restores the pattern after each copy.
module pattern_shifter
   import seq_gen_pkg::*;
#(
   parameter int unsigned PAT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 shift,
   input  logic [PAT_WIDTH-1:0] pattern_in,
   output logic                 bit_out,
   output logic                 next_bit,
   output logic                 last_bit
);

   localparam int unsigned IDX_W = clog2(PAT_WIDTH);

   logic [PAT_WIDTH-1:0] pattern;
   logic [IDX_W-1:0]     idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern <= PAT_WIDTH'(DEFAULT_PATTERN);
         idx     <= IDX_W'(PAT_WIDTH - 1);
      end else if (load) begin
         pattern <= pattern_in;
         idx     <= IDX_W'(PAT_WIDTH - 1);
      end else if (shift) begin
         pattern <= {pattern[PAT_WIDTH-2:0], pattern[PAT_WIDTH-1]};
         idx     <= (idx == '0) ? IDX_W'(PAT_WIDTH - 1) : idx - IDX_W'(1);
      end
   end

   // Current bit is the MSB; the bit presented after the next rotation sits just below it.
   assign bit_out  = pattern[PAT_WIDTH-1];
   assign next_bit = pattern[PAT_WIDTH-2];
   assign last_bit = (idx == '0);

endmodule

// File: rtl/sequence_generator_moore.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with idle gaps.
module sequence_generator_moore
   import seq_gen_pkg::*;
#(
   parameter int unsigned PAT_WIDTH  = 4,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned RPT_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PAT_WIDTH-1:0] pattern_in,
   input  logic [RPT_W-1:0]     repeat_count,
   input  logic                 abort,
   output logic                 data_out,
   output logic                 data_valid,
   output logic                 busy,
   output logic                 done,
   output logic [RPT_W-1:0]     sent_count
);

   localparam int unsigned CMP_W = RPT_W + 1;

   state_t           state;
   logic [RPT_W-1:0] rpt;
   logic             load;
   logic             shift;
   logic             bit_out;
   logic             next_bit;
   logic             last_bit;
   logic             gap_zero;
   logic             final_copy;

   assign load       = (state == IDLE) && start && !abort;
   assign shift      = (state == SHIFT) && !abort;
   assign final_copy = ({1'b0, sent_count} + CMP_W'(1)) == {1'b0, rpt};

   pattern_shifter #(
      .PAT_WIDTH (PAT_WIDTH)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .shift      (shift),
      .pattern_in (pattern_in),
      .bit_out    (bit_out),
      .next_bit   (next_bit),
      .last_bit   (last_bit)
   );

   // Idle-bit counter between copies; loaded on every last bit, only consumed in GAP.
   generate
      if (GAP_CYCLES > 0) begin : g_gap
         localparam int unsigned GAP_W = clog2(GAP_CYCLES + 1);
         logic [GAP_W-1:0] gap_cnt;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               gap_cnt <= '0;
            end else if (shift && last_bit) begin
               gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else if ((state == GAP) && (gap_cnt != '0)) begin
               gap_cnt <= gap_cnt - GAP_W'(1);
            end
         end

         assign gap_zero = (gap_cnt == '0);
      end else begin : g_no_gap
         assign gap_zero = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rpt        <= '0;
         data_out   <= 1'b0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sent_count <= '0;
      end else if (abort) begin
         state      <= IDLE;
         data_out   <= 1'b0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  rpt        <= repeat_count;
                  sent_count <= '0;
                  busy       <= 1'b1;
                  if (repeat_count != '0) begin
                     state      <= SHIFT;
                     data_valid <= 1'b1;
                     data_out   <= pattern_in[PAT_WIDTH-1];
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (last_bit) begin
                  if (sent_count != '1) sent_count <= sent_count + RPT_W'(1);
                  if (final_copy) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     data_valid <= 1'b0;
                     data_out   <= 1'b0;
                  end else if (GAP_CYCLES > 0) begin
                     state      <= GAP;
                     data_valid <= 1'b0;
                     data_out   <= 1'b0;
                  end else begin
                     data_out <= next_bit;
                  end
               end else begin
                  data_out <= next_bit;
               end
            end
            GAP: begin
               // Pattern register has rotated back to its original order here.
               if (gap_zero) begin
                  state      <= SHIFT;
                  data_valid <= 1'b1;
                  data_out   <= bit_out;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sequence_generator_moore.sv
// Scoreboard bench: stimulus queues timed expected bits/done; a negedge monitor pops and compares.
module tb_sequence_generator_moore;

   localparam int unsigned W   = 4;
   localparam int unsigned GAP = 2;

   typedef struct {
      bit         is_done;
      logic       val;
      logic [7:0] sent;
      int         at;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] pattern_in = 4'b0000;
   logic [7:0] repeat_count = 8'd0;
   logic       abort = 1'b0;
   logic       data_out, data_valid, busy, done;
   logic [7:0] sent_count;

   logic       start0 = 1'b0;
   logic [3:0] pattern0 = 4'b0000;
   logic [7:0] repeat0 = 8'd0;
   logic       abort0 = 1'b0;
   logic       data_out0, data_valid0, busy0, done0;
   logic [7:0] sent_count0;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t q[$];
   int   fires[$];
   int   done0_at = -1;
   logic [3:0] det_sh = 4'b0000;
   int   det_cnt = 0;

   sequence_generator_moore #(.PAT_WIDTH(W), .GAP_CYCLES(GAP), .RPT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .pattern_in(pattern_in),
      .repeat_count(repeat_count), .abort(abort), .data_out(data_out),
      .data_valid(data_valid), .busy(busy), .done(done), .sent_count(sent_count)
   );

   sequence_generator_moore #(.PAT_WIDTH(W), .GAP_CYCLES(0), .RPT_W(8)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .pattern_in(pattern0),
      .repeat_count(repeat0), .abort(abort0), .data_out(data_out0),
      .data_valid(data_valid0), .busy(busy0), .done(done0), .sent_count(sent_count0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic void push_burst(input logic [3:0] pat, input int rpt, input int c,
                                      input int keep, input bit with_done);
      exp_t e;
      int   t;
      int   n;
      t = c + 1;
      n = 0;
      for (int r = 0; r < rpt; r++) begin
         for (int i = W - 1; i >= 0; i--) begin
            if (n < keep) begin
               e.is_done = 1'b0; e.val = pat[i]; e.sent = 8'd0; e.at = t;
               q.push_back(e);
            end
            n++;
            t++;
         end
         if (r < rpt - 1) t += GAP;
      end
      if (with_done) begin
         e.is_done = 1'b1; e.val = 1'b0; e.sent = 8'(rpt); e.at = t;
         q.push_back(e);
      end
   endfunction

   task automatic issue(input logic [3:0] pat, input int rpt, input int keep,
                        input bit with_done, output int c);
      @(negedge clk);
      c = cyc;
      push_burst(pat, rpt, c, keep, with_done);
      start = 1'b1; pattern_in = pat; repeat_count = 8'(rpt);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         fail_now({name, "_timeout"});
         q.delete();
      end
   endtask

   // Monitor: every valid bit or done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (data_valid || done) begin
            if (q.size() == 0) begin
               fail_now("unexpected_output");
            end else begin
               e = q.pop_front();
               check("kind_is_done", 32'(done), 32'(e.is_done));
               check("event_cycle", 32'(cyc), 32'(e.at));
               if (e.is_done) begin
                  check("done_sent_count", 32'(sent_count), 32'(e.sent));
                  check("done_busy", 32'(busy), 32'd1);
               end else begin
                  check("data_bit", 32'(data_out), 32'(e.val));
               end
            end
         end else begin
            check("idle_data_out", 32'(data_out), 32'd0);
         end
      end
   end

   // Loopback detector for 1010, non-overlapping, fed by the GAP=0 instance.
   always @(negedge clk) begin
      logic       din;
      logic [3:0] nsh;
      din = data_valid0 ? data_out0 : 1'b0;
      nsh = {det_sh[2:0], din};
      det_sh = nsh;
      det_cnt++;
      if (det_cnt >= 4 && nsh == 4'b1010) begin
         fires.push_back(cyc);
         det_cnt = 0;
      end
      if (done0) done0_at = cyc;
   end

   initial begin
      int c;

      // 1: reset held with start=1, then burst starts right after release
      start = 1'b1; pattern_in = 4'b1010; repeat_count = 8'd1;
      repeat (3) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_data_valid", 32'(data_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sent_count", 32'(sent_count), 32'd0);
      @(negedge clk);
      c = cyc;
      push_burst(4'b1010, 1, c, 4, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done("t1");

      // 2: single copy of 1010
      issue(4'b1010, 1, 4, 1'b1, c);
      wait_done("t2");
      check("t2_sent_hold", 32'(sent_count), 32'd1);

      // 3: three copies with gaps; a start mid-burst is ignored
      issue(4'b1010, 3, 12, 1'b1, c);
      repeat (3) @(negedge clk);
      start = 1'b1; pattern_in = 4'b0101; repeat_count = 8'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done("t3");
      check("t3_sent_hold", 32'(sent_count), 32'd3);

      // 4: loopback through detector, back-to-back copies
      fires.delete();
      @(negedge clk);
      c = cyc;
      start0 = 1'b1; pattern0 = 4'b1010; repeat0 = 8'd2;
      @(negedge clk);
      start0 = 1'b0;
      repeat (12) @(negedge clk);
      check("t4_fire_count", 32'(fires.size()), 32'd2);
      if (fires.size() == 2) begin
         check("t4_fire0_cycle", 32'(fires[0]), 32'(c + 4));
         check("t4_fire1_cycle", 32'(fires[1]), 32'(c + 8));
      end
      check("t4_done_cycle", 32'(done0_at), 32'(c + 9));
      check("t4_sent_count", 32'(sent_count0), 32'd2);

      // 5a: repeat 0 gives only a done pulse
      issue(4'b1111, 0, 0, 1'b1, c);
      wait_done("t5a");
      check("t5a_sent", 32'(sent_count), 32'd0);

      // 5b: abort during second copy of four
      issue(4'b1010, 4, 6, 1'b0, c);
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5b_valid", 32'(data_valid), 32'd0);
      check("t5b_busy", 32'(busy), 32'd0);
      check("t5b_done", 32'(done), 32'd0);
      check("t5b_sent", 32'(sent_count), 32'd1);
      wait_done("t5b");

      // 5c: abort beats start in IDLE
      @(negedge clk);
      start = 1'b1; abort = 1'b1; pattern_in = 4'b1111; repeat_count = 8'd3;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("t5c_busy", 32'(busy), 32'd0);
      check("t5c_sent", 32'(sent_count), 32'd1);
      repeat (4) @(negedge clk);

      // 6: async reset between edges mid-SHIFT, then a clean restart
      issue(4'b1010, 2, 8, 1'b1, c);
      @(negedge clk);
      @(posedge clk);
      #2;
      q.delete();
      reset = 1'b1;
      #1;
      check("t6_valid", 32'(data_valid), 32'd0);
      check("t6_data_out", 32'(data_out), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_sent", 32'(sent_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      issue(4'b0110, 1, 4, 1'b1, c);
      wait_done("t6");
      check("t6_restart_sent", 32'(sent_count), 32'd1);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
